// File: rtl/mipi_pkg.sv
// Shared constants for the CSI-2 pattern generator and the receiver checker.
// Pattern selects, FSM encoding and LFSR parameters.
package mipi_pkg;

    localparam logic [1:0] PAT_COLRAMP = 2'd0;
    localparam logic [1:0] PAT_ROWRAMP = 2'd1;
    localparam logic [1:0] PAT_CHECKER = 2'd2;
    localparam logic [1:0] PAT_LFSR    = 2'd3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_VLEAD  = 3'd1;
    localparam logic [2:0] ST_LINE   = 3'd2;
    localparam logic [2:0] ST_HBLANK = 3'd3;
    localparam logic [2:0] ST_VBLANK = 3'd4;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting, feedback into bit 15
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // A zero-length blank would hide the href/vsync edge from the serializer
    function automatic logic [15:0] blank_min1(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

endpackage

// File: rtl/mipi_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous reseed and advance strobe.
// Shared with the CSI-2 receiver checker.
module mipi_lfsr16
    import mipi_pkg::*;
(
    input  logic        clk,
    input  logic        resetb,
    input  logic        load,
    input  logic        advance,
    output logic [15:0] q
);

    logic [15:0] r_q;
    logic        w_fb;

    assign w_fb = ^(r_q & LFSR_TAPS);
    assign q    = r_q;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_q <= LFSR_SEED;
        end else if (load) begin
            r_q <= LFSR_SEED;
        end else if (advance) begin
            r_q <= {w_fb, r_q[15:1]};
        end
    end

endmodule

// File: rtl/mipi_csi2_pattern_gen.sv
// Synthetic vsync/href/data image source feeding the CSI-2 serializer.
// Outputs are a registered decode of the FSM, one cycle behind the state.
module mipi_csi2_pattern_gen
    import mipi_pkg::*;
#(
    parameter int DATA_WIDTH = 10
) (
    input  logic                  pixclk,
    input  logic                  resetb,
    input  logic                  enable,
    input  logic [1:0]            pattern_sel,
    input  logic [3:0]            pixel_width,
    input  logic [15:0]           num_rows,
    input  logic [15:0]           num_cols,
    input  logic [15:0]           h_blank,
    input  logic [15:0]           v_blank,
    output logic                  vsync,
    output logic                  href,
    output logic [DATA_WIDTH-1:0] data,
    output logic [15:0]           frame_cnt,
    output logic [15:0]           line_cnt,
    output logic                  busy
);

    logic [2:0]            r_state;
    logic [15:0]           r_cnt;
    logic [15:0]           r_row;
    logic [15:0]           r_rows;
    logic [15:0]           r_cols;
    logic [15:0]           r_hb;
    logic [15:0]           r_vb;
    logic [1:0]            r_pat;
    logic                  r_pw8;

    logic                  r_vsync;
    logic                  r_href;
    logic [DATA_WIDTH-1:0] r_data;
    logic [15:0]           r_frame_cnt;
    logic [15:0]           r_line_cnt;
    logic                  r_busy;

    logic [15:0]           w_len;
    logic                  w_last;
    logic                  w_start;
    logic                  w_load;
    logic                  w_in_line;
    logic [15:0]           w_lfsr_q;
    logic [9:0]            w_pix_raw;
    logic [9:0]            w_mask;
    logic                  w_unused_lfsr;

    assign w_start   = enable && (num_rows != 16'd0) && (num_cols != 16'd0);
    assign w_in_line = (r_state == ST_LINE);

    always_comb begin
        w_len = 16'd1;
        case (r_state)
            ST_VLEAD:  w_len = r_hb;
            ST_HBLANK: w_len = r_hb;
            ST_LINE:   w_len = r_cols;
            ST_VBLANK: w_len = r_vb;
            default:   w_len = 16'd1;
        endcase
    end

    assign w_last = (r_cnt == w_len - 16'd1);
    assign w_load = w_start && ((r_state == ST_IDLE) ||
                                ((r_state == ST_VBLANK) && w_last));

    always_ff @(posedge pixclk or negedge resetb) begin
        if (!resetb) begin
            r_state <= ST_IDLE;
            r_cnt   <= 16'd0;
            r_row   <= 16'd0;
            r_rows  <= 16'd0;
            r_cols  <= 16'd0;
            r_hb    <= 16'd1;
            r_vb    <= 16'd1;
            r_pat   <= PAT_COLRAMP;
            r_pw8   <= 1'b0;
        end else if (w_load) begin
            r_state <= ST_VLEAD;
            r_cnt   <= 16'd0;
            r_row   <= 16'd0;
            r_rows  <= num_rows;
            r_cols  <= num_cols;
            r_hb    <= blank_min1(h_blank);
            r_vb    <= blank_min1(v_blank);
            r_pat   <= pattern_sel;
            r_pw8   <= (pixel_width == 4'd8);
        end else if (r_state != ST_IDLE) begin
            if (!w_last) begin
                r_cnt <= r_cnt + 16'd1;
            end else begin
                r_cnt <= 16'd0;
                case (r_state)
                    ST_VLEAD:  r_state <= ST_LINE;
                    ST_LINE:   r_state <= ST_HBLANK;
                    ST_HBLANK: begin
                        if (r_row == r_rows - 16'd1) begin
                            r_state <= ST_VBLANK;
                        end else begin
                            r_row   <= r_row + 16'd1;
                            r_state <= ST_LINE;
                        end
                    end
                    // VBLANK end without a restart request
                    default:   r_state <= ST_IDLE;
                endcase
            end
        end
    end

    mipi_lfsr16 u_lfsr (
        .clk     (pixclk),
        .resetb  (resetb),
        .load    (w_load),
        .advance (w_in_line),
        .q       (w_lfsr_q)
    );

    assign w_unused_lfsr = ^w_lfsr_q[15:10];

    always_comb begin
        w_pix_raw = 10'd0;
        case (r_pat)
            PAT_COLRAMP: w_pix_raw = r_cnt[9:0];
            PAT_ROWRAMP: w_pix_raw = r_row[9:0];
            PAT_CHECKER: w_pix_raw = {10{r_row[3] ^ r_cnt[3]}};
            PAT_LFSR:    w_pix_raw = w_lfsr_q[9:0];
            default:     w_pix_raw = 10'd0;
        endcase
    end

    assign w_mask = r_pw8 ? 10'h0FF : 10'h3FF;

    always_ff @(posedge pixclk or negedge resetb) begin
        if (!resetb) begin
            r_vsync     <= 1'b0;
            r_href      <= 1'b0;
            r_data      <= '0;
            r_frame_cnt <= 16'd0;
            r_line_cnt  <= 16'd0;
            r_busy      <= 1'b0;
        end else begin
            r_vsync <= (r_state == ST_VLEAD) || (r_state == ST_LINE) ||
                       (r_state == ST_HBLANK);
            r_href  <= w_in_line;
            r_data  <= w_in_line ? DATA_WIDTH'(w_pix_raw & w_mask) : '0;
            r_busy  <= (r_state != ST_IDLE);
            // r_cnt is zero only on the first cycle of each state visit
            if ((r_state == ST_VLEAD) && (r_cnt == 16'd0)) begin
                r_line_cnt <= 16'd0;
            end else if (w_in_line && (r_cnt == 16'd0)) begin
                r_line_cnt <= r_line_cnt + 16'd1;
            end
            if ((r_state == ST_VBLANK) && (r_cnt == 16'd0)) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign vsync     = r_vsync;
    assign href      = r_href;
    assign data      = r_data;
    assign frame_cnt = r_frame_cnt;
    assign line_cnt  = r_line_cnt;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mipi_csi2_pattern_gen.sv
// Directed bench for mipi_csi2_pattern_gen: per-configuration frame
// measurements from a vector table plus hand-written corner sequences.
module tb_mipi_csi2_pattern_gen;

    localparam int DW = 10;
    localparam int GUARD = 5000;

    logic          pixclk = 1'b0;
    logic          resetb = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    pattern_sel = 2'd0;
    logic [3:0]    pixel_width = 4'd10;
    logic [15:0]   num_rows = 16'd0;
    logic [15:0]   num_cols = 16'd0;
    logic [15:0]   h_blank = 16'd0;
    logic [15:0]   v_blank = 16'd0;
    logic          vsync;
    logic          href;
    logic [DW-1:0] data;
    logic [15:0]   frame_cnt;
    logic [15:0]   line_cnt;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    mipi_csi2_pattern_gen #(.DATA_WIDTH(DW)) dut (
        .pixclk      (pixclk),
        .resetb      (resetb),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .pixel_width (pixel_width),
        .num_rows    (num_rows),
        .num_cols    (num_cols),
        .h_blank     (h_blank),
        .v_blank     (v_blank),
        .vsync       (vsync),
        .href        (href),
        .data        (data),
        .frame_cnt   (frame_cnt),
        .line_cnt    (line_cnt),
        .busy        (busy)
    );

    always #5 pixclk = ~pixclk;

    typedef struct {
        logic [1:0] pat;
        logic [3:0] pw;
        int rows, cols, hb, vb;
        int hi, lo, lead, tail, bursts, hcyc, gap;
        int px0, pxlast, lbpx0;
    } vec_t;

    vec_t vecs[5];

    int m_hi, m_lo, m_lead, m_tail, m_bursts, m_hcyc, m_gap, m_bad, m_col;
    int m_lc, m_fc;
    logic m_to;
    logic [DW-1:0] m_px0, m_pxlast, m_lbpx0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge pixclk);
        resetb = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge pixclk);
        resetb = 1'b1;
        @(negedge pixclk);
    endtask

    task automatic set_cfg(input logic [1:0] pat, input logic [3:0] pw,
                           input int rows, input int cols,
                           input int hb, input int vb);
        pattern_sel = pat;
        pixel_width = pw;
        num_rows    = 16'(rows);
        num_cols    = 16'(cols);
        h_blank     = 16'(hb);
        v_blank     = 16'(vb);
    endtask

    // One frame from vsync rise through the following vsync-low period.
    task automatic measure();
        int g;
        logic prev;
        m_hi = 0; m_lo = 0; m_lead = -1; m_tail = 0; m_bursts = 0;
        m_hcyc = 0; m_gap = 0; m_bad = 0; m_col = 0; m_to = 1'b0;
        m_px0 = '0; m_pxlast = '0; m_lbpx0 = '0;
        prev = 1'b0;
        g = 0;
        while (vsync !== 1'b1 && g < GUARD) begin
            @(negedge pixclk);
            g++;
        end
        while (vsync === 1'b1 && g < GUARD) begin
            m_hi++;
            if (href === 1'b1) begin
                if (!prev) begin
                    if (m_bursts > 0) m_gap = m_tail;
                    else m_lead = m_hi - 1;
                    m_bursts++;
                    m_col = 0;
                    m_lbpx0 = data;
                end
                if (m_bursts == 1) begin
                    if (m_col == 0) m_px0 = data;
                    m_pxlast = data;
                end
                m_col++;
                m_hcyc++;
                m_tail = 0;
            end else begin
                if (data !== '0) m_bad++;
                m_tail++;
            end
            prev = href;
            @(negedge pixclk);
            g++;
        end
        m_lc = line_cnt;
        m_fc = frame_cnt;
        while (vsync !== 1'b1 && g < GUARD) begin
            m_lo++;
            if (href !== 1'b0 || data !== '0) m_bad++;
            @(negedge pixclk);
            g++;
        end
        m_to = (g >= GUARD);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, b, cnt, hi;
        logic prev;
        string p;

        //          pat pw rows cols hb vb  hi lo ld tl bu hc gp  px0 pxl lbpx0
        vecs[0] = '{2'd0, 4'd10, 2, 4, 3, 5, 17, 5, 3, 3, 2, 8, 3, 0, 3, 0};
        vecs[1] = '{2'd0, 4'd10, 3, 2, 0, 0, 10, 1, 1, 1, 3, 6, 1, 0, 1, 0};
        vecs[2] = '{2'd1, 4'd10, 3, 2, 2, 2, 14, 2, 2, 2, 3, 6, 2, 0, 0, 2};
        vecs[3] = '{2'd2, 4'd8,  1, 9, 1, 1, 11, 1, 1, 1, 1, 9, 0,
                    0, 'hFF, 0};
        vecs[4] = '{2'd3, 4'd10, 2, 3, 1, 1, 9, 1, 1, 1, 2, 6, 1,
                    'h0E1, 'h338, 'h19C};

        // Reset state and start latency
        repeat (2) @(negedge pixclk);
        chk("rst_vsync", vsync, 0);
        chk("rst_href", href, 0);
        chk("rst_data", data, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_line_cnt", line_cnt, 0);
        chk("rst_busy", busy, 0);
        resetb = 1'b1;
        set_cfg(2'd0, 4'd10, 2, 4, 3, 5);
        @(negedge pixclk);
        enable = 1'b1;
        @(posedge pixclk);
        #1 chk("latency_edge_n", vsync, 0);
        @(posedge pixclk);
        #1 chk("latency_edge_n1", vsync, 1);
        chk("latency_busy", busy, 1);

        // Table: two consecutive frames per configuration
        for (int i = 0; i < 5; i++) begin
            do_reset();
            set_cfg(vecs[i].pat, vecs[i].pw, vecs[i].rows, vecs[i].cols,
                    vecs[i].hb, vecs[i].vb);
            enable = 1'b1;
            for (int f = 1; f <= 2; f++) begin
                measure();
                p = $sformatf("v%0d f%0d ", i, f);
                chk({p, "timeout"}, m_to, 0);
                chk({p, "vs_hi"}, m_hi, vecs[i].hi);
                chk({p, "vs_lo"}, m_lo, vecs[i].lo);
                chk({p, "lead"}, m_lead, vecs[i].lead);
                chk({p, "tail"}, m_tail, vecs[i].tail);
                chk({p, "bursts"}, m_bursts, vecs[i].bursts);
                chk({p, "href_cyc"}, m_hcyc, vecs[i].hcyc);
                chk({p, "gap"}, m_gap, vecs[i].gap);
                chk({p, "px0"}, m_px0, vecs[i].px0);
                chk({p, "pxlast"}, m_pxlast, vecs[i].pxlast);
                chk({p, "lastline_px0"}, m_lbpx0, vecs[i].lbpx0);
                chk({p, "blank_data"}, m_bad, 0);
                chk({p, "line_cnt"}, m_lc, vecs[i].rows);
                chk({p, "frame_cnt"}, m_fc, f);
            end
            enable = 1'b0;
        end

        // Enable dropped during line 1: frame completes, then IDLE
        do_reset();
        set_cfg(2'd0, 4'd10, 4, 2, 1, 2);
        enable = 1'b1;
        b = 0; hi = 0; g = 0; prev = 1'b0;
        while (vsync !== 1'b1 && g < 500) begin
            @(negedge pixclk);
            g++;
        end
        while (vsync === 1'b1 && g < 500) begin
            hi++;
            if (href === 1'b1 && !prev) begin
                b++;
                if (b == 2) enable = 1'b0;
            end
            prev = href;
            @(negedge pixclk);
            g++;
        end
        chk("drop_bursts", b, 4);
        chk("drop_vs_hi", hi, 13);
        cnt = 0;
        while (busy === 1'b1 && vsync === 1'b0 && g < 500) begin
            cnt++;
            @(negedge pixclk);
            g++;
        end
        chk("drop_timeout", (g < 500), 1);
        chk("drop_vblank", cnt, 2);
        chk("drop_busy", busy, 0);
        chk("drop_frame_cnt", frame_cnt, 1);
        cnt = 0;
        repeat (60) begin
            @(negedge pixclk);
            if (vsync !== 1'b0 || busy !== 1'b0) cnt++;
        end
        chk("drop_stays_idle", cnt, 0);

        // num_cols changed mid-frame takes effect on the next frame
        do_reset();
        set_cfg(2'd0, 4'd10, 2, 4, 2, 2);
        enable = 1'b1;
        g = 0;
        while (vsync !== 1'b1 && g < 500) begin
            @(negedge pixclk);
            g++;
        end
        num_cols = 16'd6;
        measure();
        chk("chg_f1_href_cyc", m_hcyc, 8);
        chk("chg_f1_vs_hi", m_hi, 14);
        measure();
        chk("chg_f2_href_cyc", m_hcyc, 12);
        chk("chg_f2_vs_hi", m_hi, 18);
        chk("chg_f2_pxlast", m_pxlast, 5);

        // Reset asserted mid-line
        g = 0;
        while (href !== 1'b1 && g < 500) begin
            @(negedge pixclk);
            g++;
        end
        chk("midrst_href_seen", href, 1);
        chk("midrst_frame_cnt_pre", frame_cnt, 2);
        resetb = 1'b0;
        #1;
        chk("midrst_vsync", vsync, 0);
        chk("midrst_href", href, 0);
        chk("midrst_data", data, 0);
        chk("midrst_frame_cnt", frame_cnt, 0);
        chk("midrst_line_cnt", line_cnt, 0);
        chk("midrst_busy", busy, 0);
        @(negedge pixclk);
        resetb = 1'b1;
        @(posedge pixclk);
        #1 chk("restart_edge_n", vsync, 0);
        @(posedge pixclk);
        #1 chk("restart_edge_n1", vsync, 1);

        // Zero geometry keeps the block idle
        do_reset();
        set_cfg(2'd0, 4'd10, 0, 4, 1, 1);
        enable = 1'b1;
        cnt = 0;
        repeat (100) begin
            @(negedge pixclk);
            if (busy !== 1'b0 || vsync !== 1'b0) cnt++;
        end
        chk("zero_rows_idle", cnt, 0);
        num_rows = 16'd3;
        num_cols = 16'd0;
        cnt = 0;
        repeat (50) begin
            @(negedge pixclk);
            if (busy !== 1'b0 || vsync !== 1'b0) cnt++;
        end
        chk("zero_cols_idle", cnt, 0);
        enable = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
